// File: rtl/pipelined_control_unit.sv
// ==== pipelined_control_unit: pipelined MIPS ID decode with EX/MEM/WB control bundle ====
// ==== load-use interlock, HI/LO busy tracking, branch flush              -- rev 1.0   ====
`default_nettype none

module pipelined_control_unit #(
  parameter int MULT_CYCLES        = 4,
  parameter int DIV_CYCLES         = 32,
  parameter int COUNT_WIDTH        = 6,
  parameter int LOAD_USE_INTERLOCK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instructionData,
  input  logic        instructionValid,
  input  logic        flush,
  output logic        stall,
  output logic        hiloBusy,
  output logic        ex_valid,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_shamt,
  output logic        ex_useImmediate,
  output logic        ex_signExtend,
  output logic [3:0]  ex_branchMode,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [2:0]  mem_readMode,
  output logic [2:0]  mem_writeMode,
  output logic        mem_unsignedLoad,
  output logic        wb_registerWrite,
  output logic [4:0]  wb_writeAddress,
  output logic [1:0]  wb_writeSource
);

  // Branch modes, memory modes, write sources, destination selectors
  localparam logic [3:0] BR_NONE = 4'd0, BR_EQ = 4'd1, BR_NE = 4'd2, BR_LEZ = 4'd3,
                         BR_GTZ = 4'd4, BR_LTZ = 4'd5, BR_GEZ = 4'd6, BR_J = 4'd7, BR_JR = 4'd8;
  localparam logic [2:0] MEM_NONE = 3'd0, MEM_BYTE = 3'd1, MEM_HALF = 3'd2, MEM_WORD = 3'd3;
  localparam logic [1:0] WS_NONE = 2'd0, WS_RESULT = 2'd1, WS_MEMORY = 2'd2, WS_NEXT_PC = 2'd3;
  localparam logic [1:0] DST_NONE = 2'd0, DST_RD = 2'd1, DST_RT = 2'd2, DST_RA = 2'd3;
  localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2a, F_SLTU = 6'h2b;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = instructionData[31:26];
  assign rs = instructionData[25:21];
  assign rt = instructionData[20:16];
  assign rd = instructionData[15:11];
  assign fn = instructionData[5:0];

  logic       dec_valid, dec_use_imm, dec_sext, dec_unsigned, dec_regw;
  logic       reads_rs, reads_rt, dec_hilo, dec_mult, dec_div;
  logic [5:0] dec_funct;
  logic [4:0] dec_shamt, dec_addr;
  logic [3:0] dec_branch;
  logic [2:0] dec_read, dec_write;
  logic [1:0] dec_dst, dec_src;

  always_comb begin
    dec_valid = 1'b1;  dec_funct = 6'd0;     dec_shamt = 5'd0;    dec_use_imm = 1'b0;
    dec_sext = 1'b0;   dec_branch = BR_NONE; dec_read = MEM_NONE; dec_write = MEM_NONE;
    dec_unsigned = 1'b0; dec_regw = 1'b0;    dec_dst = DST_NONE;  dec_src = WS_NONE;
    reads_rs = 1'b1;   reads_rt = 1'b0;      dec_hilo = 1'b0;     dec_mult = 1'b0;
    dec_div = 1'b0;
    case (op)
      6'h00: begin
        reads_rt = 1'b1; dec_funct = fn; dec_shamt = instructionData[10:6];
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            dec_regw = 1'b1; dec_dst = DST_RD; dec_src = WS_RESULT;
          end
          6'h08: dec_branch = BR_JR;
          6'h09: begin
            dec_branch = BR_JR; dec_regw = 1'b1; dec_dst = DST_RD; dec_src = WS_NEXT_PC;
          end
          6'h10, 6'h12: begin
            dec_hilo = 1'b1; dec_regw = 1'b1; dec_dst = DST_RD; dec_src = WS_RESULT;
          end
          6'h11, 6'h13: dec_hilo = 1'b1;
          6'h18, 6'h19: begin dec_hilo = 1'b1; dec_mult = 1'b1; end
          6'h1a, 6'h1b: begin dec_hilo = 1'b1; dec_div = 1'b1; end
          default: dec_valid = 1'b0;
        endcase
      end
      6'h01: begin
        dec_sext = 1'b1;
        if (rt == 5'd0)      dec_branch = BR_LTZ;
        else if (rt == 5'd1) dec_branch = BR_GEZ;
        else                 dec_valid = 1'b0;
      end
      6'h02: begin reads_rs = 1'b0; dec_branch = BR_J; end
      6'h03: begin
        reads_rs = 1'b0; dec_branch = BR_J; dec_regw = 1'b1; dec_dst = DST_RA; dec_src = WS_NEXT_PC;
      end
      6'h04, 6'h05: begin
        reads_rt = 1'b1; dec_funct = F_SUB; dec_sext = 1'b1;
        dec_branch = (op == 6'h04) ? BR_EQ : BR_NE;
      end
      6'h06: begin dec_sext = 1'b1; dec_branch = BR_LEZ; end
      6'h07: begin dec_sext = 1'b1; dec_branch = BR_GTZ; end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec_use_imm = 1'b1; dec_regw = 1'b1; dec_dst = DST_RT; dec_src = WS_RESULT;
        dec_sext = (op <= 6'h0b);
        case (op)
          6'h08:   dec_funct = F_ADD;
          6'h09:   dec_funct = F_ADDU;
          6'h0a:   dec_funct = F_SLT;
          6'h0b:   dec_funct = F_SLTU;
          6'h0c:   dec_funct = F_AND;
          6'h0d:   dec_funct = F_OR;
          6'h0e:   dec_funct = F_XOR;
          default: begin dec_funct = F_SLL; dec_shamt = 5'd16; end
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_funct = F_ADD; dec_use_imm = 1'b1; dec_sext = 1'b1;
        dec_regw = 1'b1; dec_dst = DST_RT; dec_src = WS_MEMORY;
        dec_unsigned = (op == 6'h24) || (op == 6'h25);
        dec_read = (op == 6'h23) ? MEM_WORD : ((op == 6'h21 || op == 6'h25) ? MEM_HALF : MEM_BYTE);
      end
      6'h28, 6'h29, 6'h2b: begin
        dec_funct = F_ADD; dec_use_imm = 1'b1; dec_sext = 1'b1; reads_rt = 1'b1;
        dec_write = (op == 6'h2b) ? MEM_WORD : ((op == 6'h29) ? MEM_HALF : MEM_BYTE);
      end
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    case (dec_dst)
      DST_RD:  dec_addr = rd;
      DST_RT:  dec_addr = rt;
      DST_RA:  dec_addr = 5'd31;
      default: dec_addr = 5'd0;
    endcase
  end

  // Control bundle riding along EX and MEM toward WB
  logic [2:0]             ex_readMode, ex_writeMode;
  logic                   ex_unsignedLoad, ex_registerWrite, mem_registerWrite;
  logic [4:0]             ex_writeAddress, mem_writeAddress;
  logic [1:0]             ex_writeSource, mem_writeSource;
  logic [COUNT_WIDTH-1:0] hilo_count;
  logic                   load_use, hilo_hazard, accept;

  assign load_use = (LOAD_USE_INTERLOCK != 0) && ex_valid && (ex_readMode != MEM_NONE) &&
                    (ex_writeAddress != 5'd0) && dec_valid &&
                    ((reads_rs && rs == ex_writeAddress) || (reads_rt && rt == ex_writeAddress));
  assign hilo_hazard = (hilo_count != '0) && dec_valid && dec_hilo;
  assign stall       = instructionValid && !flush && (load_use || hilo_hazard);
  assign hiloBusy    = (hilo_count != '0);
  assign accept      = instructionValid && !flush && !stall && dec_valid;

  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      ex_valid <= 1'b0;       ex_funct <= 6'd0;        ex_shamt <= 5'd0;
      ex_useImmediate <= 1'b0; ex_signExtend <= 1'b0;  ex_branchMode <= BR_NONE;
      ex_rs <= 5'd0;          ex_rt <= 5'd0;           ex_readMode <= MEM_NONE;
      ex_writeMode <= MEM_NONE; ex_unsignedLoad <= 1'b0; ex_registerWrite <= 1'b0;
      ex_writeAddress <= 5'd0; ex_writeSource <= WS_NONE;
    end else begin
      ex_valid <= 1'b1;       ex_funct <= dec_funct;   ex_shamt <= dec_shamt;
      ex_useImmediate <= dec_use_imm; ex_signExtend <= dec_sext; ex_branchMode <= dec_branch;
      ex_rs <= rs;            ex_rt <= rt;             ex_readMode <= dec_read;
      ex_writeMode <= dec_write; ex_unsignedLoad <= dec_unsigned;
      ex_registerWrite <= dec_regw && (dec_addr != 5'd0);
      ex_writeAddress <= dec_addr; ex_writeSource <= dec_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_readMode <= MEM_NONE; mem_writeMode <= MEM_NONE; mem_unsignedLoad <= 1'b0;
      mem_registerWrite <= 1'b0; mem_writeAddress <= 5'd0; mem_writeSource <= WS_NONE;
      wb_registerWrite <= 1'b0; wb_writeAddress <= 5'd0; wb_writeSource <= WS_NONE;
    end else begin
      mem_readMode <= ex_readMode; mem_writeMode <= ex_writeMode;
      mem_unsignedLoad <= ex_unsignedLoad; mem_registerWrite <= ex_registerWrite;
      mem_writeAddress <= ex_writeAddress; mem_writeSource <= ex_writeSource;
      wb_registerWrite <= mem_registerWrite; wb_writeAddress <= mem_writeAddress;
      wb_writeSource <= mem_writeSource;
    end
  end

  // Busy count loads as the multicycle op enters EX, then drains to zero
  always_ff @(posedge clk) begin
    if (rst)                      hilo_count <= '0;
    else if (accept && dec_mult)  hilo_count <= COUNT_WIDTH'(MULT_CYCLES - 1);
    else if (accept && dec_div)   hilo_count <= COUNT_WIDTH'(DIV_CYCLES - 1);
    else if (hilo_count != '0)    hilo_count <= hilo_count - 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
// ==== tb_pipelined_control_unit: directed self-checking bench for pipelined_control_unit ====
`default_nettype none

module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instructionData = 32'd0;
  logic        instructionValid = 1'b0;
  logic        flush = 1'b0;

  logic       stall, hiloBusy, ex_valid, ex_useImmediate, ex_signExtend, mem_unsignedLoad;
  logic       wb_registerWrite;
  logic [5:0] ex_funct;
  logic [4:0] ex_shamt, ex_rs, ex_rt, wb_writeAddress;
  logic [3:0] ex_branchMode;
  logic [2:0] mem_readMode, mem_writeMode;
  logic [1:0] wb_writeSource;

  logic       nl_stall, nl_hiloBusy, nl_ex_valid, nl_ex_useImmediate, nl_ex_signExtend;
  logic       nl_mem_unsignedLoad, nl_wb_registerWrite;
  logic [5:0] nl_ex_funct;
  logic [4:0] nl_ex_shamt, nl_ex_rs, nl_ex_rt, nl_wb_writeAddress;
  logic [3:0] nl_ex_branchMode;
  logic [2:0] nl_mem_readMode, nl_mem_writeMode;
  logic [1:0] nl_wb_writeSource;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .instructionData(instructionData),
    .instructionValid(instructionValid), .flush(flush), .stall(stall), .hiloBusy(hiloBusy),
    .ex_valid(ex_valid), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
    .ex_useImmediate(ex_useImmediate), .ex_signExtend(ex_signExtend),
    .ex_branchMode(ex_branchMode), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_readMode(mem_readMode), .mem_writeMode(mem_writeMode),
    .mem_unsignedLoad(mem_unsignedLoad), .wb_registerWrite(wb_registerWrite),
    .wb_writeAddress(wb_writeAddress), .wb_writeSource(wb_writeSource)
  );

  pipelined_control_unit #(.LOAD_USE_INTERLOCK(0)) dut_nl (
    .clk(clk), .rst(rst), .instructionData(instructionData),
    .instructionValid(instructionValid), .flush(flush), .stall(nl_stall),
    .hiloBusy(nl_hiloBusy), .ex_valid(nl_ex_valid), .ex_funct(nl_ex_funct),
    .ex_shamt(nl_ex_shamt), .ex_useImmediate(nl_ex_useImmediate),
    .ex_signExtend(nl_ex_signExtend), .ex_branchMode(nl_ex_branchMode),
    .ex_rs(nl_ex_rs), .ex_rt(nl_ex_rt), .mem_readMode(nl_mem_readMode),
    .mem_writeMode(nl_mem_writeMode), .mem_unsignedLoad(nl_mem_unsignedLoad),
    .wb_registerWrite(nl_wb_registerWrite), .wb_writeAddress(nl_wb_writeAddress),
    .wb_writeSource(nl_wb_writeSource)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instructionValid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
    tests++; if (hiloBusy !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL reset_busy_stall got=%0b%0b exp=00", hiloBusy, stall); end
    tests++; if (wb_registerWrite !== 1'b0 || ex_funct !== 6'd0) begin fails++; $display("FAIL reset_bundle got=%0b/%0h exp=0/0", wb_registerWrite, ex_funct); end
  endtask

  task automatic test_addi();
    instructionData = 32'h20080005; instructionValid = 1'b1;
    tick();
    instructionValid = 1'b0;
    tests++; if (ex_valid !== 1'b1 || ex_funct !== 6'h20) begin fails++; $display("FAIL addi_ex got=%0b/%0h exp=1/20", ex_valid, ex_funct); end
    tests++; if (ex_useImmediate !== 1'b1 || ex_signExtend !== 1'b1) begin fails++; $display("FAIL addi_imm got=%0b%0b exp=11", ex_useImmediate, ex_signExtend); end
    tick(); tick();
    tests++; if (wb_registerWrite !== 1'b1 || wb_writeAddress !== 5'd8 || wb_writeSource !== 2'd1)
      begin fails++; $display("FAIL addi_wb got=%0b/%0d/%0d exp=1/8/1", wb_registerWrite, wb_writeAddress, wb_writeSource); end
    idle(2);
  endtask

  task automatic test_load_use();
    instructionData = 32'h8D090000; instructionValid = 1'b1;
    tick();
    instructionData = 32'h01295020;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL loaduse_stall got=%0b exp=1", stall); end
    tests++; if (nl_stall !== 1'b0) begin fails++; $display("FAIL loaduse_nointerlock_stall got=%0b exp=0", nl_stall); end
    tests++; if (mem_readMode !== 3'd0) begin fails++; $display("FAIL loaduse_mem_idle got=%0d exp=0", mem_readMode); end
    tick();
    tests++; if (ex_valid !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL loaduse_bubble got=%0b/%0b exp=0/0", ex_valid, stall); end
    tests++; if (nl_ex_valid !== 1'b1 || nl_ex_funct !== 6'h20) begin fails++; $display("FAIL loaduse_nointerlock_add got=%0b/%0h exp=1/20", nl_ex_valid, nl_ex_funct); end
    tests++; if (mem_readMode !== 3'd3) begin fails++; $display("FAIL loaduse_lw_mem got=%0d exp=3", mem_readMode); end
    tick();
    instructionValid = 1'b0;
    tests++; if (ex_valid !== 1'b1 || ex_funct !== 6'h20 || ex_rs !== 5'd9 || ex_rt !== 5'd9)
      begin fails++; $display("FAIL loaduse_add_late got=%0b/%0h/%0d/%0d exp=1/20/9/9", ex_valid, ex_funct, ex_rs, ex_rt); end
    idle(3);
  endtask

  task automatic test_hilo();
    instructionData = 32'h01090018; instructionValid = 1'b1;
    tick();
    instructionData = 32'h00005012;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (hiloBusy !== 1'b1 || stall !== 1'b1) begin fails++; $display("FAIL hilo_busy_%0d got=%0b%0b exp=11", i, hiloBusy, stall); end
      tick();
      tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL hilo_bubble_%0d got=%0b exp=0", i, ex_valid); end
    end
    tests++; if (hiloBusy !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL hilo_drained got=%0b%0b exp=00", hiloBusy, stall); end
    tick();
    instructionValid = 1'b0;
    tests++; if (ex_valid !== 1'b1 || ex_funct !== 6'h12) begin fails++; $display("FAIL hilo_mflo_ex got=%0b/%0h exp=1/12", ex_valid, ex_funct); end
    idle(3);
  endtask

  task automatic test_flush();
    instructionData = 32'h8D090000; instructionValid = 1'b1;
    tick();
    instructionData = 32'h01295020; flush = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_over_stall got=%0b exp=0", stall); end
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_bubble got=%0b exp=0", ex_valid); end
    instructionData = 32'h0109001A;
    tick();
    tests++; if (hiloBusy !== 1'b0 || ex_valid !== 1'b0) begin fails++; $display("FAIL flush_div got=%0b/%0b exp=0/0", hiloBusy, ex_valid); end
    idle(3);
  endtask

  task automatic test_dest();
    instructionData = 32'h20000001; instructionValid = 1'b1;
    tick();
    instructionData = 32'h0C000010;
    tick();
    instructionValid = 1'b0;
    tests++; if (ex_branchMode !== 4'd7 || ex_valid !== 1'b1) begin fails++; $display("FAIL jal_branch got=%0d/%0b exp=7/1", ex_branchMode, ex_valid); end
    tick();
    tests++; if (wb_registerWrite !== 1'b0) begin fails++; $display("FAIL zero_dest_write got=%0b exp=0", wb_registerWrite); end
    tick();
    tests++; if (wb_registerWrite !== 1'b1 || wb_writeAddress !== 5'd31 || wb_writeSource !== 2'd3)
      begin fails++; $display("FAIL jal_wb got=%0b/%0d/%0d exp=1/31/3", wb_registerWrite, wb_writeAddress, wb_writeSource); end
    idle(3);
  endtask

  task automatic test_reset_mid_div();
    instructionData = 32'h0109001A; instructionValid = 1'b1;
    tick();
    instructionData = 32'h20080005;
    tick();
    instructionData = 32'h00005012;
    tick(); tick();
    tests++; if (wb_registerWrite !== 1'b1 || hiloBusy !== 1'b1 || stall !== 1'b1)
      begin fails++; $display("FAIL div_inflight got=%0b%0b%0b exp=111", wb_registerWrite, hiloBusy, stall); end
    tick();
    rst = 1'b1;
    tick();
    tests++; if (hiloBusy !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rst_div_busy got=%0b%0b exp=00", hiloBusy, stall); end
    tests++; if (ex_valid !== 1'b0 || wb_registerWrite !== 1'b0) begin fails++; $display("FAIL rst_div_pipe got=%0b/%0b exp=0/0", ex_valid, wb_registerWrite); end
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_hilo();
    test_flush();
    test_dest();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
